// File: rtl/mem_access.sv
// Memory stage: drives a single-outstanding req/gnt/rvalid data bus for
// loads/stores, steers store byte lanes, extracts/extends load data, and
// presents one registered result per instruction to writeback.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [1:0]  mem_op,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_buserr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wb_valid_q, wb_valid_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_mis_q, wb_mis_d;
  logic             wb_err_q, wb_err_d;

  logic        is_mem_c;
  logic        misalign_c;
  logic        accept_c;
  logic        timeout_c;
  logic [3:0]  lane_be_c;
  logic [31:0] lane_wdata_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] load_data_c;

  // Decode the incoming instruction: alignment and store lane steering
  always_comb begin
    is_mem_c     = valid_in & ((mem_op == OP_LOAD) | (mem_op == OP_STORE));
    misalign_c   = 1'b0;
    lane_be_c    = 4'b1111;
    lane_wdata_c = rs2_data;
    case (mem_size)
      SZ_BYTE: begin
        lane_be_c    = 4'b0001 << alu_out[1:0];
        lane_wdata_c = {4{rs2_data[7:0]}};
      end
      SZ_HALF: begin
        misalign_c   = alu_out[0];
        lane_be_c    = alu_out[1] ? 4'b1100 : 4'b0011;
        lane_wdata_c = {2{rs2_data[15:0]}};
      end
      default: misalign_c = |alu_out[1:0];
    endcase
    accept_c  = (state_q == S_IDLE) & is_mem_c & ~misalign_c;
    timeout_c = (cnt_q >= CNT_LAST);
  end

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    ld_byte_c = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half_c = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_data_c = {{24{~uns_q & ld_byte_c[7]}}, ld_byte_c};
      SZ_HALF: load_data_c = {{16{~uns_q & ld_half_c[15]}}, ld_half_c};
      default: load_data_c = dmem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_mis_d   = 1'b0;
    wb_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (!is_mem_c) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_out;
          end else if (misalign_c) begin
            wb_valid_d = 1'b1;
            wb_mis_d   = 1'b1;
            wb_data_d  = alu_out;
          end else begin
            addr_d  = alu_out;
            size_d  = mem_size;
            uns_d   = mem_unsigned;
            we_d    = (mem_op == OP_STORE);
            be_d    = lane_be_c;
            wdata_d = (mem_op == OP_STORE) ? lane_wdata_c : 32'h0;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          req_d = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
          if (we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = 32'h0;
            state_d    = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end else if (timeout_c) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = addr_q;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = load_data_c;
          state_d    = S_IDLE;
        end else if (timeout_c) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = addr_q;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_mis_q   <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_mis_q   <= wb_mis_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign stall       = (state_q != S_IDLE) | accept_c;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = {addr_q[31:2], 2'b00};
  assign dmem_be     = be_q;
  assign dmem_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_mis_q;
  assign wb_buserr   = wb_err_q;

endmodule
